// File: rtl/ebus_dev.sv
// KL10 EBUS device responder: decodes CONO/CONI/DATAO/DATAI for one controller
// select, runs the demand/ack handshake, and bridges data through two FIFOs.
module ebus_dev #(
    parameter logic [6:0] DEV_CS = 7'o040,
    parameter int         DEPTH  = 4
) (
    input  logic        clk,
    input  logic        CROBAR,
    input  logic [0:6]  ebus_cs,
    input  logic [0:2]  ebus_func,
    input  logic        ebus_demand,
    input  logic [0:35] ebus_data_in,
    output logic        ebus_ack,
    output logic        ebus_xfer,
    output logic        ebus_drv,
    output logic [0:35] ebus_data_out,
    output logic [1:7]  ebus_pi,
    output logic        dev_rd_valid,
    input  logic        dev_rd_ready,
    output logic [0:35] dev_rd_data,
    input  logic        dev_wr_valid,
    output logic        dev_wr_ready,
    input  logic [0:35] dev_wr_data
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DECODE, ACK, DROP} state_t;

    state_t         state, state_nx;
    logic [0:2]     func_q;
    logic [0:35]    data_q, out_reg;
    logic [2:0]     pia;
    logic           en, ovr, und;

    logic [0:35]    omem [DEPTH];
    logic [0:35]    imem [DEPTH];
    logic [AW-1:0]  o_wp, o_rp, i_wp, i_rp;
    logic [CW-1:0]  o_cnt, i_cnt;

    logic           do_op, is_cono, is_coni, is_datao, is_datai;
    logic           o_full, i_full, o_push, o_pop, i_push, i_pop;
    logic [0:35]    status, out_nx;
    logic [2:0]     pia_nx;
    logic           en_nx, ovr_nx, und_nx;
    logic [CW-1:0]  o_cnt_nx, i_cnt_nx;
    logic [1:7]     pi_nx;
    logic           drive_nx;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding its old value (no latch inferred).
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (ebus_demand && ebus_cs == DEV_CS && !ebus_func[0])
                        state_nx = DECODE;
            DECODE: state_nx = ebus_demand ? ACK : IDLE;
            ACK:    if (!ebus_demand) state_nx = DROP;
            DROP:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_op    = (state == DECODE) && ebus_demand;
        is_cono  = do_op && (func_q == 3'b000);
        is_coni  = do_op && (func_q == 3'b001);
        is_datao = do_op && (func_q == 3'b010);
        is_datai = do_op && (func_q == 3'b011);

        o_full = (o_cnt == FULL);
        i_full = (i_cnt == FULL);
        // A device pop on the same edge frees the slot a full-FIFO DATAO needs.
        o_pop  = dev_rd_ready && (o_cnt != '0);
        o_push = is_datao && (!o_full || o_pop);
        i_push = dev_wr_valid && !i_full;
        i_pop  = is_datai && (i_cnt != '0);

        status         = '0;
        status[27]     = ovr;
        status[28]     = und;
        status[29]     = o_full;
        status[30]     = (i_cnt != '0);
        status[31]     = en;
        status[33:35]  = pia;

        pia_nx = pia;
        en_nx  = en;
        ovr_nx = ovr;
        und_nx = und;
        out_nx = out_reg;
        if (is_cono) begin
            pia_nx = data_q[33:35];
            en_nx  = data_q[31];
            if (data_q[32]) begin
                ovr_nx = 1'b0;
                und_nx = 1'b0;
            end
        end
        if (is_datao && !o_push) ovr_nx = 1'b1;
        if (is_coni) out_nx = status;
        if (is_datai) begin
            out_nx = i_pop ? imem[i_rp] : '0;
            if (!i_pop) und_nx = 1'b1;
        end

        o_cnt_nx = o_cnt + CW'(o_push) - CW'(o_pop);
        i_cnt_nx = i_cnt + CW'(i_push) - CW'(i_pop);

        pi_nx = '0;
        for (int i = 1; i <= 7; i++)
            pi_nx[i] = (pia_nx == 3'(i)) && ((en_nx && i_cnt_nx != '0) || ovr_nx || und_nx);

        drive_nx = (state_nx == ACK) && func_q[2];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state         <= IDLE;
            func_q        <= '0;
            data_q        <= '0;
            out_reg       <= '0;
            pia           <= '0;
            en            <= 1'b0;
            ovr           <= 1'b0;
            und           <= 1'b0;
            o_wp          <= '0;
            o_rp          <= '0;
            i_wp          <= '0;
            i_rp          <= '0;
            o_cnt         <= '0;
            i_cnt         <= '0;
            ebus_ack      <= 1'b0;
            ebus_xfer     <= 1'b0;
            ebus_drv      <= 1'b0;
            ebus_data_out <= '0;
            ebus_pi       <= '0;
            dev_rd_valid  <= 1'b0;
            dev_wr_ready  <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == DECODE) begin
                func_q <= ebus_func;
                data_q <= ebus_data_in;
            end
            out_reg <= out_nx;
            pia     <= pia_nx;
            en      <= en_nx;
            ovr     <= ovr_nx;
            und     <= und_nx;
            if (o_push) o_wp <= o_wp + AW'(1);
            if (o_pop)  o_rp <= o_rp + AW'(1);
            if (i_push) i_wp <= i_wp + AW'(1);
            if (i_pop)  i_rp <= i_rp + AW'(1);
            o_cnt <= o_cnt_nx;
            i_cnt <= i_cnt_nx;

            ebus_ack      <= (state_nx == ACK);
            ebus_xfer     <= drive_nx;
            ebus_drv      <= drive_nx;
            ebus_data_out <= drive_nx ? out_nx : '0;
            ebus_pi       <= pi_nx;
            dev_rd_valid  <= (o_cnt_nx != '0);
            dev_wr_ready  <= (i_cnt_nx != FULL);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and counts define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (o_push) omem[o_wp] <= data_q;
        if (i_push) imem[i_wp] <= dev_wr_data;
    end

    assign dev_rd_data = omem[o_rp];

endmodule

// File: tb/tb_ebus_dev.sv
// Self-checking bench for ebus_dev: directed handshake cases plus random
// transfers compared against a transaction-level queue model.
module tb_ebus_dev;

    localparam logic [6:0] CS    = 7'o040;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        CROBAR = 1'b1;
    logic [0:6]  ebus_cs = '0;
    logic [0:2]  ebus_func = '0;
    logic        ebus_demand = 1'b0;
    logic [0:35] ebus_data_in = '0;
    logic        ebus_ack, ebus_xfer, ebus_drv;
    logic [0:35] ebus_data_out;
    logic [1:7]  ebus_pi;
    logic        dev_rd_valid, dev_wr_ready;
    logic        dev_rd_ready = 1'b0;
    logic        dev_wr_valid = 1'b0;
    logic [0:35] dev_rd_data;
    logic [0:35] dev_wr_data = '0;

    always #5 clk = ~clk;

    ebus_dev #(.DEV_CS(CS), .DEPTH(DEPTH)) dut (
        .clk(clk), .CROBAR(CROBAR),
        .ebus_cs(ebus_cs), .ebus_func(ebus_func), .ebus_demand(ebus_demand),
        .ebus_data_in(ebus_data_in), .ebus_ack(ebus_ack), .ebus_xfer(ebus_xfer),
        .ebus_drv(ebus_drv), .ebus_data_out(ebus_data_out), .ebus_pi(ebus_pi),
        .dev_rd_valid(dev_rd_valid), .dev_rd_ready(dev_rd_ready), .dev_rd_data(dev_rd_data),
        .dev_wr_valid(dev_wr_valid), .dev_wr_ready(dev_wr_ready), .dev_wr_data(dev_wr_data)
    );

    // Reference model: device-visible state as plain queues and flags.
    logic [35:0] oq[$];
    logic [35:0] iq[$];
    int          pia;
    bit          en, ovr, und;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic logic [1:7] exp_pi();
        logic [1:7] e = '0;
        if (pia != 0 && ((en && iq.size() != 0) || ovr || und)) e[pia] = 1'b1;
        return e;
    endfunction

    function automatic logic [35:0] exp_status();
        return (36'(ovr) << 8) | (36'(und) << 7) | (36'(oq.size() == DEPTH) << 6) |
               (36'(iq.size() != 0) << 5) | (36'(en) << 4) | 36'(pia);
    endfunction

    task automatic model_reset();
        oq.delete();
        iq.delete();
        pia = 0;
        en  = 1'b0;
        ovr = 1'b0;
        und = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ack"}, ebus_ack, 0);
        check({tag, ".pi"}, ebus_pi, exp_pi());
        check({tag, ".rd_valid"}, dev_rd_valid, oq.size() != 0);
        check({tag, ".wr_ready"}, dev_wr_ready, iq.size() < DEPTH);
        if (oq.size() != 0) check({tag, ".rd_data"}, dev_rd_data, oq[0]);
    endtask

    // Full bus transfer: demand, two-cycle ack latency, one extra ACK cycle, release.
    task automatic bus_op(input logic [2:0] f, input logic [35:0] d);
        logic [35:0] exp;
        bit          rd;
        rd = f[0];
        @(negedge clk);
        ebus_cs = CS; ebus_func = f; ebus_data_in = d; ebus_demand = 1'b1;
        @(negedge clk);
        check("op.decode_ack", ebus_ack, 0);
        exp = '0;
        case (f)
            3'd0: begin
                pia = int'(d[2:0]);
                en  = d[4];
                if (d[3]) begin ovr = 1'b0; und = 1'b0; end
            end
            3'd1: exp = exp_status();
            3'd2: if (oq.size() < DEPTH) oq.push_back(d); else ovr = 1'b1;
            default: if (iq.size() != 0) exp = iq.pop_front();
                     else begin exp = '0; und = 1'b1; end
        endcase
        @(negedge clk);
        check("op.ack", ebus_ack, 1);
        check("op.xfer", ebus_xfer, rd);
        check("op.drv", ebus_drv, rd);
        check("op.data", ebus_data_out, rd ? exp : 36'd0);
        check("op.pi", ebus_pi, exp_pi());
        @(negedge clk);
        check("op.hold_ack", ebus_ack, 1);
        check("op.hold_data", ebus_data_out, rd ? exp : 36'd0);
        ebus_demand = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("op.rel_xfer", ebus_xfer, 0);
        check("op.rel_drv", ebus_drv, 0);
        check("op.rel_data", ebus_data_out, 0);
        check_idle("op");
    endtask

    task automatic dev_push(input logic [35:0] d);
        @(negedge clk);
        dev_wr_valid = 1'b1; dev_wr_data = d;
        @(negedge clk);
        if (iq.size() < DEPTH) iq.push_back(d);
        check_idle("push");
        dev_wr_valid = 1'b0;
    endtask

    task automatic dev_pop();
        @(negedge clk);
        dev_rd_ready = 1'b1;
        @(negedge clk);
        if (oq.size() != 0) void'(oq.pop_front());
        check_idle("pop");
        dev_rd_ready = 1'b0;
    endtask

    task automatic bad_sel(input logic [6:0] cs, input logic [2:0] f);
        @(negedge clk);
        ebus_cs = cs; ebus_func = f; ebus_data_in = 36'o17; ebus_demand = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bad.ack", ebus_ack, 0);
            check("bad.drv", ebus_drv, 0);
        end
        ebus_demand = 1'b0;
        @(negedge clk);
        check_idle("bad");
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        CROBAR = 1'b0;
        check("rst.xfer", ebus_xfer, 0);
        check("rst.drv", ebus_drv, 0);
        check("rst.data", ebus_data_out, 0);
        check_idle("rst");

        // CONO EN=1 PIA=5, read it back, then DONE raises PI level 5.
        bus_op(3'd0, 36'o25);
        bus_op(3'd1, 36'd0);
        dev_push(36'o1234);
        check("pi5", ebus_pi, 7'b0000100);

        // Reset asserted while ACKing a DATAI.
        @(negedge clk);
        ebus_cs = CS; ebus_func = 3'd3; ebus_demand = 1'b1;
        repeat (2) @(negedge clk);
        check("rstack.ack_before", ebus_ack, 1);
        CROBAR = 1'b1;
        @(negedge clk);
        CROBAR = 1'b0; ebus_demand = 1'b0;
        model_reset();
        check("rstack.drv", ebus_drv, 0);
        check("rstack.data", ebus_data_out, 0);
        check_idle("rstack");

        // Output FIFO overflow, drain order, OVR clear.
        for (int i = 1; i <= 5; i++) bus_op(3'd2, 36'(i));
        bus_op(3'd1, 36'd0);
        for (int i = 0; i < 4; i++) dev_pop();
        bus_op(3'd0, 36'o10);
        bus_op(3'd1, 36'd0);

        // Input FIFO underflow, then all-ones word.
        bus_op(3'd0, 36'o24);
        bus_op(3'd3, 36'd0);
        dev_push(36'o777777777777);
        bus_op(3'd3, 36'd0);
        bus_op(3'd1, 36'd0);
        bus_op(3'd0, 36'o10);

        // Foreign select and reserved function are never acknowledged.
        bad_sel(7'o041, 3'd3);
        bad_sel(CS, 3'b101);
        bus_op(3'd1, 36'd0);

        // Demand withdrawn during DECODE of a DATAO.
        @(negedge clk);
        ebus_cs = CS; ebus_func = 3'd2; ebus_data_in = 36'o55; ebus_demand = 1'b1;
        @(negedge clk);
        ebus_demand = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wd.ack", ebus_ack, 0);
        end
        check_idle("wd");

        // Full output FIFO: device pop and DATAO push on the same edge.
        for (int i = 0; i < DEPTH; i++) bus_op(3'd2, 36'o100 + 36'(i));
        @(negedge clk);
        ebus_cs = CS; ebus_func = 3'd2; ebus_data_in = 36'o123; ebus_demand = 1'b1;
        @(negedge clk);
        dev_rd_ready = 1'b1;
        @(negedge clk);
        dev_rd_ready = 1'b0; ebus_demand = 1'b0;
        void'(oq.pop_front());
        oq.push_back(36'o123);
        check("same.ack", ebus_ack, 1);
        repeat (2) @(negedge clk);
        check_idle("same");
        bus_op(3'd1, 36'd0);
        for (int i = 0; i < DEPTH; i++) dev_pop();

        // Random mix of bus transfers and device-side traffic.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0: bus_op(3'd0, {4'($urandom), 32'($urandom)});
                1: bus_op(3'd1, 36'd0);
                2: bus_op(3'd2, {4'($urandom), 32'($urandom)});
                3: bus_op(3'd3, 36'd0);
                4, 5: dev_push({4'($urandom), 32'($urandom)});
                default: dev_pop();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
